// File: rtl/merge_fifo.sv
// Show-ahead FIFO feeding merge comparators: head entry is always on o_dout while o_valid.
// Optional sticky protocol-error flag is compiled in when MERGE_FIFO_ERR_EN is defined.
module merge_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_din,
  input  logic                  i_enq,
  output logic                  o_full,
  output logic [DATA_WIDTH-1:0] o_dout,
  output logic                  o_valid,
  input  logic                  i_deq,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned PW    = DEPTH_LOG2;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wp;
  logic [PW-1:0]         r_rp;
  logic [CW-1:0]         r_count;

  logic                  w_full;
  logic                  w_valid;
  logic                  w_wr;
  logic                  w_rd;

  // Status flags decode registered occupancy only; requests never reach outputs combinationally.
  always_comb begin
    w_full  = (r_count == FULL_CNT);
    w_valid = (r_count != '0);
    w_wr    = i_enq & ~w_full;
    w_rd    = i_deq & w_valid;
  end

  // Storage array carries no reset; occupancy decides what is meaningful.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_wr) begin
      r_mem[r_wp] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_wp <= r_wp + PW'(1);
      end
      if (w_rd) begin
        r_rp <= r_rp + PW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef MERGE_FIFO_ERR_EN
  logic r_err;

  // Sticky until reset: overflow or underflow attempt seen in any cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else if ((i_enq & w_full) | (i_deq & ~w_valid)) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

  always_comb begin
    o_full  = w_full;
    o_valid = w_valid;
    o_count = r_count;
    o_dout  = w_valid ? r_mem[r_rp] : '0;
  end

endmodule
